intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
External-interrupt front end that sits directly upstream of the CSR block.
- Synchronises and debounces an asynchronous request line, then latches a pending interrupt.
- Issues the single-cycle take_intr that drives the CSR block (MEPC latch, MSTATUS update) and the PC redirect to MTVEC.
- Gates that request with MSTATUS.MIE, MTVEC-programmed status and the core's instruction boundary, and enforces a lockout window after MRET.

Parameters:
SYNC_STAGES, 2, flops in the intr_in synchroniser chain (min 2)
DEBOUNCE_CYCLES, 4, consecutive synchronised-high cycles required to qualify a request (min 1)
LOCKOUT_CYCLES, 8, cycles after MRET before a new interrupt may be taken (min 1)
CNT_W, 8, width of intr_count

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
intr_in  in  1  asynchronous external request (button/peripheral), level
instr_boundary  in  1  core is at an instruction boundary and may redirect this cycle
mie  in  1  MSTATUS.MIE from CSR block
mtvec_ready  in  1  MTVEC programmed flag from CSR block
do_mret  in  1  MRET executing this cycle (same signal given to CSR block)
take_intr  out  1  take interrupt now; one-cycle pulse
intr_pending  out  1  qualified request latched, not yet taken
in_isr  out  1  FSM in ISR state
intr_count  out  CNT_W  interrupts taken since reset, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, immediate): synchroniser flops 0; debounce count 0; armed=1; pending 0; state IDLE; lockout counter 0; intr_count 0. take_intr, intr_pending and in_isr are 0 while rst is high and on the first cycle after release.
- Synchroniser: SYNC_STAGES-flop chain; sync_q is the last stage. No logic on intr_in before the first flop.
- Debounce and edge qualification:
  - The counter increments each edge sync_q=1 and saturates at DEBOUNCE_CYCLES. It clears on any edge with sync_q=0.
  - A qualified event fires on the edge the counter reaches DEBOUNCE_CYCLES while armed=1. armed then clears.
  - armed is set again only on an edge with sync_q=0. Result: one event per press, and glitches shorter than DEBOUNCE_CYCLES are ignored.
- Latency: with defaults, intr_in going high before edge k gives intr_pending=1 after edge k+5, i.e. SYNC_STAGES+DEBOUNCE_CYCLES edges counting edge k.
- Pending latch:
  - Set by a qualified event; cleared on the edge where take_intr=1.
  - An event in the same cycle as take_intr wins, so pending stays 1.
  - Events while already pending merge; there is no queueing.
- FSM states: IDLE, ISR, LOCKOUT.
  - IDLE: take_intr = pending & mie & mtvec_ready & instr_boundary, combinational and asserted in the same cycle. Next edge: state ISR, intr_count+1. do_mret in IDLE is ignored.
  - ISR: take_intr=0, in_isr=1. On do_mret go to LOCKOUT and load the counter with LOCKOUT_CYCLES. Events during ISR still set pending.
  - LOCKOUT: take_intr=0, in_isr=0. Counter decrements each edge; when it reads 1, next state is IDLE. take_intr is possible LOCKOUT_CYCLES+1 cycles after the do_mret cycle at the earliest.
- mie or mtvec_ready low: pending is held indefinitely, nothing is dropped, take_intr stays 0.
- instr_boundary low: take_intr stays 0 and is re-evaluated every cycle.
- intr_count wraps 2^CNT_W-1 → 0.

Test Plan:
1. Reset, mie=1, mtvec_ready=1, instr_boundary=1; intr_in high from before edge 10 → intr_pending=1 after edge 15; take_intr=1 during cycle 16 only; in_isr=1 and intr_count=1 after edge 16; pending=0.
2. intr_in pulsed high for 3 cycles with default DEBOUNCE_CYCLES=4 → intr_pending never asserts; intr_count stays 0.
3. Qualified event with mtvec_ready=0 → pending held 50 cycles, take_intr=0. Raise mtvec_ready → take_intr pulses that same cycle.
4. In ISR, second press qualifies; do_mret pulsed at cycle T → in_isr=0 at T+1; take_intr=0 through cycle T+8; take_intr=1 at cycle T+9 with instr_boundary=1.
5. Hold intr_in high 100 cycles → exactly one take_intr. Release, then re-press → second take_intr after MRET+lockout; intr_count=2.
6. Assert rst mid-LOCKOUT with pending=1 → all outputs 0 immediately (async), state IDLE. A do_mret after release has no effect.

Source files
------------

// File: rtl/intr_ctrl_if.sv
// Interrupt front-end bus between the core/CSR side (master) and intr_ctrl (slave).
interface intr_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             intr_in;
  logic             instr_boundary;
  logic             mie;
  logic             mtvec_ready;
  logic             do_mret;
  logic             take_intr;
  logic             intr_pending;
  logic             in_isr;
  logic [CNT_W-1:0] intr_count;

  modport master (
    output intr_in, instr_boundary, mie, mtvec_ready, do_mret,
    input  take_intr, intr_pending, in_isr, intr_count
  );

  modport slave (
    input  intr_in, instr_boundary, mie, mtvec_ready, do_mret,
    output take_intr, intr_pending, in_isr, intr_count
  );
endinterface

// File: rtl/intr_ctrl.sv
// External interrupt front end: synchronise, debounce, latch pending, and sequence
// take/ISR/post-MRET lockout ahead of the CSR block.
module intr_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8,
  parameter int CNT_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  intr_ctrl_if.slave  bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LK_W-1:0] LK_LOAD = LK_W'(LOCKOUT_CYCLES);
  localparam logic [LK_W-1:0] LK_ONE  = LK_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISR, S_LOCKOUT} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_armed;
  logic                   r_pending;
  logic [LK_W-1:0]        r_lock_cnt;
  logic [CNT_W-1:0]       r_count;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_sync_q;
  logic                   w_event;
  logic                   w_take;
  logic                   w_in_isr;

  assign w_sync_q = r_sync[SYNC_STAGES-1];
  // Event fires on the edge the run of highs reaches DEBOUNCE_CYCLES, once per press.
  assign w_event  = w_sync_q && r_armed && (r_db_cnt == DB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.intr_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt <= '0;
      r_armed  <= 1'b1;
    end else if (!w_sync_q) begin
      r_db_cnt <= '0;
      r_armed  <= 1'b1;
    end else begin
      if (r_db_cnt != DB_MAX) r_db_cnt <= r_db_cnt + 1'b1;
      if (w_event)            r_armed  <= 1'b0;
    end
  end

  // A new event in the take cycle wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_event || (r_pending && !w_take);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lock_cnt <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_ISR && bus.do_mret) begin
        r_lock_cnt <= LK_LOAD;
      end else if (r_state == S_LOCKOUT && r_lock_cnt != '0) begin
        r_lock_cnt <= r_lock_cnt - 1'b1;
      end
      if (w_take) r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_take)               w_state_nxt = S_ISR;
      S_ISR:     if (bus.do_mret)          w_state_nxt = S_LOCKOUT;
      S_LOCKOUT: if (r_lock_cnt == LK_ONE) w_state_nxt = S_IDLE;
      default:                             w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_take   = 1'b0;
    w_in_isr = 1'b0;
    case (r_state)
      S_IDLE:  w_take   = r_pending && bus.mie && bus.mtvec_ready && bus.instr_boundary;
      S_ISR:   w_in_isr = 1'b1;
      default: ;
    endcase
  end

  assign bus.take_intr    = w_take;
  assign bus.intr_pending = r_pending;
  assign bus.in_isr       = w_in_isr;
  assign bus.intr_count   = r_count;

endmodule

// File: tb/tb_intr_ctrl.sv
// Randomised and directed bench for intr_ctrl against a cycle-level behavioural model.
module tb_intr_ctrl;

  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int LOCK  = 8;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  intr_ctrl_if #(.CNT_W(CNT_W)) bus();

  intr_ctrl #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LOCK), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Driven inputs for the current cycle
  bit d_in, d_ib, d_mie, d_mtv, d_mret;

  // Model: sync line modelled as a delay queue, debounce as run length of highs,
  // lockout as an absolute cycle number before which no take is allowed.
  bit          m_q[$];
  int          m_run;
  bit          m_pend, m_isr;
  int          m_lock_end;
  int unsigned m_cnt;
  int          cyc;

  logic             o_take, o_pend, o_isr;
  logic [CNT_W-1:0] o_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
    m_run = 0; m_pend = 0; m_isr = 0; m_lock_end = 0; m_cnt = 0; cyc = 1;
  endtask

  // Called just after a falling edge: drive, check, advance model, wait next falling edge.
  task automatic step(input string tag);
    bit sq, ev, tk;
    bus.intr_in = d_in; bus.instr_boundary = d_ib; bus.mie = d_mie;
    bus.mtvec_ready = d_mtv; bus.do_mret = d_mret;
    #1;
    o_take = bus.take_intr; o_pend = bus.intr_pending;
    o_isr  = bus.in_isr;    o_cnt  = bus.intr_count;
    tk = m_pend && d_mie && d_mtv && d_ib && !m_isr && (cyc >= m_lock_end);
    chk({tag, "_take"}, 32'(o_take), 32'(tk));
    chk({tag, "_pend"}, 32'(o_pend), 32'(m_pend));
    chk({tag, "_isr"},  32'(o_isr),  32'(m_isr));
    chk({tag, "_cnt"},  32'(o_cnt),  m_cnt % (1 << CNT_W));
    sq = m_q.pop_front();
    m_q.push_back(d_in);
    m_run = sq ? m_run + 1 : 0;
    ev = sq && (m_run == DEB);
    if (tk) begin
      m_isr = 1; m_cnt++;
    end else if (m_isr && d_mret) begin
      m_isr = 0; m_lock_end = cyc + LOCK + 1;
    end
    m_pend = ev || (m_pend && !tk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // Async reset asserted mid-cycle; outputs must drop before any clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_take", 32'(bus.take_intr),    0);
    chk("rst_pend", 32'(bus.intr_pending), 0);
    chk("rst_isr",  32'(bus.in_isr),       0);
    chk("rst_cnt",  32'(bus.intr_count),   0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic all_on();
    d_in = 0; d_ib = 1; d_mie = 1; d_mtv = 1; d_mret = 0;
  endtask

  int takes, pend_seen, t_mret, seg;

  initial begin
    all_on();
    bus.intr_in = 0; bus.instr_boundary = 1; bus.mie = 1; bus.mtvec_ready = 1; bus.do_mret = 0;
    @(negedge clk);
    do_reset();

    // Latency: press from cycle 10 -> pending seen in cycle 16 with take in that cycle
    for (int c = 1; c <= 20; c++) begin
      d_in = (c >= 10);
      step("t1");
      if (c == 1)  chk("t1_first_take", 32'(o_take), 0);
      if (c == 15) chk("t1_pend15", 32'(o_pend), 0);
      if (c == 16) begin
        chk("t1_pend16", 32'(o_pend), 1);
        chk("t1_take16", 32'(o_take), 1);
      end
      if (c == 17) begin
        chk("t1_take17", 32'(o_take), 0);
        chk("t1_isr17",  32'(o_isr),  1);
        chk("t1_cnt17",  32'(o_cnt),  1);
        chk("t1_pend17", 32'(o_pend), 0);
      end
    end
    d_in = 0; steps("t1r", 3);
    d_mret = 1; step("t1m"); d_mret = 0;
    steps("t1l", 12);

    // Glitch shorter than debounce is ignored
    pend_seen = 0;
    d_in = 1; steps("t2", 3);
    d_in = 0;
    for (int i = 0; i < 12; i++) begin
      step("t2");
      if (o_pend) pend_seen++;
    end
    chk("t2_pend_seen", pend_seen, 0);
    chk("t2_cnt", 32'(o_cnt), 1);

    // mtvec not ready: pending held, no take; take the same cycle it rises
    d_mtv = 0; d_in = 1; takes = 0;
    for (int i = 0; i < 60; i++) begin
      step("t3");
      if (o_take) takes++;
    end
    chk("t3_takes", takes, 0);
    chk("t3_pend",  32'(o_pend), 1);
    d_mtv = 1; step("t3go");
    chk("t3_take", 32'(o_take), 1);

    // Second press qualifies during ISR; lockout timing after MRET at cycle T
    d_in = 0; steps("t4r", 4);
    d_in = 1; steps("t4p", 8);
    chk("t4_pend_isr", 32'(o_pend), 1);
    d_mret = 1; t_mret = cyc; step("t4m"); d_mret = 0;
    for (int i = 1; i <= LOCK; i++) begin
      step("t4l");
      if (i == 1) chk("t4_isr_t1", 32'(o_isr), 0);
      chk("t4_lock_take", 32'(o_take), 0);
    end
    step("t4go");
    chk("t4_take_t9", 32'(o_take), 1);
    chk("t4_t9_cycle", cyc - 1 - t_mret, LOCK + 1);
    d_in = 0; steps("t4r", 4);

    // Long hold yields exactly one take; re-press after lockout yields the second
    do_reset();
    all_on(); takes = 0;
    d_in = 1;
    for (int i = 0; i < 100; i++) begin
      d_mret = (i == 40);
      step("t5h");
      if (o_take) takes++;
    end
    d_mret = 0;
    chk("t5_one_take", takes, 1);
    d_in = 0; steps("t5r", 10);
    d_in = 1;
    for (int i = 0; i < 12; i++) begin
      step("t5p");
      if (o_take) takes++;
    end
    chk("t5_two_takes", takes, 2);
    chk("t5_cnt", 32'(o_cnt), 2);

    // Reset in LOCKOUT with pending; MRET afterwards is ignored
    d_in = 0; steps("t6r", 6);
    d_in = 1; steps("t6p", 8);
    d_mret = 1; step("t6m"); d_mret = 0;
    steps("t6l", 3);
    chk("t6_pend_lock", 32'(o_pend), 1);
    chk("t6_isr_lock",  32'(o_isr),  0);
    do_reset();
    d_in = 0; d_mret = 1; step("t6x"); d_mret = 0;
    steps("t6y", 5);
    chk("t6_isr_after", 32'(o_isr), 0);
    chk("t6_cnt_after", 32'(o_cnt), 0);

    // Randomised traffic, long enough for intr_count to wrap
    do_reset();
    seg = 0;
    for (int i = 0; i < 9000; i++) begin
      if (seg == 0) begin
        d_in = !d_in;
        seg  = d_in ? $urandom_range(1, 10) : $urandom_range(1, 6);
      end
      seg--;
      d_ib   = ($urandom_range(0, 3) != 0);
      d_mie  = ($urandom_range(0, 15) != 0);
      d_mtv  = ($urandom_range(0, 15) != 0);
      d_mret = ($urandom_range(0, 3) == 0);
      step("rnd");
    end
    chk("rnd_wrapped", 32'(m_cnt >= (1 << CNT_W)), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
